// File: rtl/alu_ct_mdu.sv
// ALU control decoder with an iterative unsigned multiply/divide sequencer and HI/LO registers.
// Optional feature: define ALU_CT_DIV_EN to build and decode the divu datapath.
module alu_ct_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [1:0]       alu_ct_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       alu_ct,
    output logic             stall,
    output logic             md_sel,
    output logic [WIDTH-1:0] md_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state;
    logic               r_ack;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_ph;
    logic [WIDTH-1:0]   r_pl;
    logic [WIDTH-1:0]   r_opd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [3:0]         w_dec;
    logic               w_rtype;
    logic               w_div_req;
    logic               w_req;
    logic [WIDTH:0]     w_madd;
    logic [2*WIDTH-1:0] w_nxt;
`ifdef ALU_CT_DIV_EN
    logic               r_is_div;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_div_nxt;
`endif

    always_comb begin
        w_dec = 4'b0000;
        case (alu_ct_op)
            2'b00: w_dec = 4'b0010;
            2'b01: w_dec = 4'b0110;
            2'b10: begin
                case (funct)
                    6'b100000, 6'b100001: w_dec = 4'b0010;
                    6'b100010, 6'b100011: w_dec = 4'b0110;
                    6'b100100:            w_dec = 4'b0000;
                    6'b100101:            w_dec = 4'b0001;
                    6'b100110:            w_dec = 4'b0011;
                    6'b100111:            w_dec = 4'b1100;
                    6'b101010:            w_dec = 4'b0111;
                    6'b101011:            w_dec = 4'b1000;
                    6'b001000:            w_dec = 4'b0010;
                    default:              w_dec = 4'b0000;
                endcase
            end
            default: w_dec = 4'b0000;
        endcase
    end

    assign w_rtype = rst && (alu_ct_op == 2'b10);
    assign alu_ct  = rst ? w_dec : 4'b0000;
    assign md_sel  = w_rtype && ((funct == F_MFHI) || (funct == F_MFLO));
    assign md_out  = (w_rtype && funct == F_MFHI) ? r_hi :
                     (w_rtype && funct == F_MFLO) ? r_lo : '0;
    assign hi      = r_hi;
    assign lo      = r_lo;

`ifdef ALU_CT_DIV_EN
    assign w_div_req = valid && w_rtype && (funct == F_DIVU);
`else
    assign w_div_req = 1'b0;
`endif
    assign w_req = (valid && w_rtype && (funct == F_MULTU)) || w_div_req;
    assign stall = (w_req && !r_ack) || (r_state == S_RUN);

    // Shift-add step: the multiplier sits in r_pl and is consumed LSB first.
    assign w_madd = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_opd} : '0);

`ifdef ALU_CT_DIV_EN
    // Restoring step: r_ph is the partial remainder, r_pl shifts dividend out and quotient in.
    assign w_shift   = {r_ph, r_pl[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_opd};
    assign w_div_nxt = w_diff[WIDTH] ? {w_shift[WIDTH-1:0], r_pl[WIDTH-2:0], 1'b0}
                                     : {w_diff[WIDTH-1:0],  r_pl[WIDTH-2:0], 1'b1};
    assign w_nxt     = r_is_div ? w_div_nxt : {w_madd, r_pl[WIDTH-1:1]};
`else
    assign w_nxt     = {w_madd, r_pl[WIDTH-1:1]};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_ack    <= 1'b0;
            r_cnt    <= '0;
            r_ph     <= '0;
            r_pl     <= '0;
            r_opd    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef ALU_CT_DIV_EN
            r_is_div <= 1'b0;
`endif
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req && !r_ack) begin
                        r_state  <= S_RUN;
                        r_cnt    <= '0;
                        r_ph     <= '0;
                        r_pl     <= w_div_req ? a : b;
                        r_opd    <= w_div_req ? b : a;
`ifdef ALU_CT_DIV_EN
                        r_is_div <= w_div_req;
`endif
                    end
                end
                S_RUN: begin
                    r_ph  <= w_nxt[2*WIDTH-1:WIDTH];
                    r_pl  <= w_nxt[WIDTH-1:0];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_hi    <= w_nxt[2*WIDTH-1:WIDTH];
                        r_lo    <= w_nxt[WIDTH-1:0];
                        r_ack   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ct_mdu.sv
// Bench for alu_ct_mdu: decode vector table plus multi-cycle MDU sequences.
module tb_alu_ct_mdu;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         valid;
    logic [1:0]   alu_ct_op;
    logic [5:0]   funct;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   alu_ct;
    logic         stall;
    logic         md_sel;
    logic [W-1:0] md_out;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad   = 0;

    alu_ct_mdu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .valid(valid), .alu_ct_op(alu_ct_op), .funct(funct),
        .a(a), .b(b), .alu_ct(alu_ct), .stall(stall), .md_sel(md_sel),
        .md_out(md_out), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       vld;
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] alu;
        logic       sel;
        logic       stl;
    } vec_t;

    vec_t tbl [0:18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue an MDU op and count stall cycles; returns in the cycle after the stall drops.
    task automatic mdu_op(input string nm, input logic [5:0] fn, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input int exp_cyc,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int cnt;
        next_cycle();
        valid = 1'b1; alu_ct_op = 2'b10; funct = fn; a = av; b = bv;
        #1;
        cnt = 0;
        while (stall && cnt < 100) begin
            cnt++;
            if (cnt == 5) begin
                a = 32'h1234_5678;
                b = 32'h0000_0009;
            end
            next_cycle();
        end
        chk({nm, "_stall_cycles"}, 64'(cnt), 64'(exp_cyc));
        chk({nm, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({nm, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'b00, 6'b000000, 4'b0010, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 2'b01, 6'b000000, 4'b0110, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 2'b11, 6'b100000, 4'b0000, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 2'b10, 6'b100000, 4'b0010, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 2'b10, 6'b100001, 4'b0010, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 2'b10, 6'b100010, 4'b0110, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 2'b10, 6'b100011, 4'b0110, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 2'b10, 6'b100100, 4'b0000, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 2'b10, 6'b100101, 4'b0001, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 2'b10, 6'b100110, 4'b0011, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 2'b10, 6'b100111, 4'b1100, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 2'b10, 6'b101010, 4'b0111, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 2'b10, 6'b101011, 4'b1000, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 2'b10, 6'b001000, 4'b0010, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 2'b10, 6'b010000, 4'b0000, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 2'b10, 6'b010010, 4'b0000, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 2'b10, 6'b111111, 4'b0000, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 2'b10, 6'b011000, 4'b0000, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 2'b10, 6'b011001, 4'b0000, 1'b0, 1'b0};

        rst = 1'b0; valid = 1'b1; alu_ct_op = 2'b10; funct = 6'b100001;
        a = '0; b = '0;
        #1;
        chk("rst_alu_ct", 64'(alu_ct), 64'h0);
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        #1;
        chk("rel_addu", 64'(alu_ct), 64'h2);
        alu_ct_op = 2'b01; #1;
        chk("rel_sub", 64'(alu_ct), 64'h6);
        alu_ct_op = 2'b10; funct = 6'b001000; #1;
        chk("rel_jr", 64'(alu_ct), 64'h2);

        for (int i = 0; i <= 18; i++) begin
            next_cycle();
            valid = tbl[i].vld; alu_ct_op = tbl[i].op; funct = tbl[i].fn;
            #1;
            chk($sformatf("vec%0d_alu_ct", i), 64'(alu_ct), 64'(tbl[i].alu));
            chk($sformatf("vec%0d_md_sel", i), 64'(md_sel), 64'(tbl[i].sel));
            chk($sformatf("vec%0d_stall", i), 64'(stall), 64'(tbl[i].stl));
        end
        next_cycle();
        chk("valid0_no_start", 64'(stall), 64'h0);

        mdu_op("multu_max", 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001);
        next_cycle();
        funct = 6'b010000; #1;
        chk("mfhi_sel", 64'(md_sel), 64'h1);
        chk("mfhi_out", 64'(md_out), 64'hFFFF_FFFE);
        funct = 6'b010010; #1;
        chk("mflo_out", 64'(md_out), 64'h1);

`ifdef ALU_CT_DIV_EN
        mdu_op("divu_100_7", 6'b011011, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        mdu_op("divu_5_0", 6'b011011, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF);
`else
        mdu_op("divu_off", 6'b011011, 32'd100, 32'd7, 0, 32'hFFFF_FFFE, 32'h0000_0001);
        chk("divu_off_alu_ct", 64'(alu_ct), 64'h0);
`endif

        mdu_op("multu_3x4", 6'b011001, 32'd3, 32'd4, 33, 32'd0, 32'd12);
        chk("ack_cycle_stall", 64'(stall), 64'h0);
        next_cycle();
        valid = 1'b0; #1;
        chk("no_restart", 64'(stall), 64'h0);
        mdu_op("multu_reissue", 6'b011001, 32'd5, 32'd6, 33, 32'd0, 32'd30);

        next_cycle();
        valid = 1'b1; alu_ct_op = 2'b10; funct = 6'b011001; a = 32'hFFFF_FFFF; b = 32'd2;
        for (int i = 0; i < 10; i++) next_cycle();
        chk("midrun_stall", 64'(stall), 64'h1);
        rst = 1'b0; #1;
        chk("abort_stall", 64'(stall), 64'h0);
        chk("abort_hi", 64'(hi), 64'h0);
        chk("abort_lo", 64'(lo), 64'h0);
        valid = 1'b0;
        next_cycle();
        rst = 1'b1;
        mdu_op("multu_after_rst", 6'b011001, 32'd3, 32'd4, 33, 32'd0, 32'd12);

        next_cycle();
        valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
